// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, control encodings and FSM states for the multi-cycle sequencer
package multicycle_control_pkg;
  localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h6, OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'hA, OP_BNE = 4'hE, OP_JMP = 4'hF;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b011, ALU_SLT = 3'b111;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_ONE = 2'b01, SRCB_IMM = 2'b10;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_ILLEGAL = 2'b01, ERR_TIMEOUT = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
    S_MEM_RD, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;
  function automatic logic [2:0] alu_for(input logic [3:0] op);
    return op == OP_OR ? ALU_OR : op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB :
           op == OP_SLT ? ALU_SLT : ALU_AND;
  endfunction
endpackage

// File: rtl/multicycle_control_timeout_counter.sv
// mc_timeout_counter: counts memory wait cycles; o_tc flags the last cycle allowed before timeout
module mc_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int TW = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  // a further miss this cycle would make the count reach TIMEOUT
  assign o_tc = r_cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer spreading each instruction over fetch/decode/execute/memory/writeback
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opCode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRwrite,
  output logic       IorD,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSrc,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUop,
  output logic       regDst,
  output logic       regWrite,
  output logic       MemtoReg,
  output logic       Memread,
  output logic       Memwrite,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] err_code
);
  state_t     r_state;
  logic [1:0] r_err;
  logic [3:0] r_op;
  logic       w_wait, w_tc, w_unused;
  // branch gating on zero happens in the datapath
  assign w_unused = zero;
  assign w_wait = (r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;
  mc_timeout_counter #(.TIMEOUT(TIMEOUT), .TW(TW)) u_tmo (
    .i_clk(clock), .i_rst(reset), .i_clr(!w_wait), .i_en(w_wait), .o_tc(w_tc)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_err   <= ERR_NONE;
      r_op    <= OP_AND;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH, S_MEM_RD, S_MEM_WR:
          if (mem_ready) r_state <= r_state == S_FETCH ? S_DECODE : r_state == S_MEM_RD ? S_WB_LW : S_FETCH;
          else if (w_tc) begin
            r_state <= S_HALT;
            r_err   <= ERR_TIMEOUT;
          end
        S_DECODE: begin
          r_op <= opCode;
          if (opCode inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT}) r_state <= S_EXEC_R;
          else if (opCode inside {OP_LW, OP_SW}) r_state <= S_ADDR;
          else if (opCode == OP_BNE) r_state <= S_BRANCH;
          else if (opCode == OP_JMP) r_state <= S_JUMP;
          else begin
            r_state <= S_HALT;
            r_err   <= ERR_ILLEGAL;
          end
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_ADDR:   r_state <= opCode == OP_SW ? S_MEM_WR : S_MEM_RD;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end
  always_comb begin
    {IRwrite, IorD, pcWrite, pcWriteCond, ALUsrcA, regDst, regWrite, MemtoReg, Memread, Memwrite, instr_done} = '0;
    pcSrc   = PC_ALU;
    ALUsrcB = SRCB_REG;
    ALUop   = ALU_AND;
    case (r_state)
      S_FETCH: begin
        Memread = 1'b1;
        IRwrite = mem_ready;
        pcWrite = mem_ready;
        ALUsrcB = SRCB_ONE;
        ALUop   = ALU_ADD;
      end
      S_DECODE: begin
        ALUsrcB = SRCB_IMM;
        ALUop   = ALU_ADD;
      end
      S_EXEC_R: begin
        ALUsrcA = 1'b1;
        ALUop   = alu_for(r_op);
      end
      S_WB_R: {regDst, regWrite, instr_done} = 3'b111;
      S_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = SRCB_IMM;
        ALUop   = ALU_ADD;
      end
      S_MEM_RD: {Memread, IorD} = 2'b11;
      S_WB_LW:  {regWrite, MemtoReg, instr_done} = 3'b111;
      S_MEM_WR: begin
        {Memwrite, IorD} = 2'b11;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        {ALUsrcA, pcWriteCond, instr_done} = 3'b111;
        ALUop = ALU_SUB;
        pcSrc = PC_ALUOUT;
      end
      S_JUMP: begin
        {pcWrite, instr_done} = 2'b11;
        pcSrc = PC_JUMP;
      end
      default: ;
    endcase
  end
  assign halted   = r_state == S_HALT;
  assign err_code = r_err;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked cycle by cycle against a phase-sequence model
module tb_multicycle_control;
  localparam int TO = 4;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_WBR = 4, P_ADDR = 5;
  localparam int P_MRD = 6, P_WLW = 7, P_MWR = 8, P_BR = 9, P_JMP = 10, P_HALT = 11;
  logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opCode = 4'h0;
  logic IRwrite, IorD, pcWrite, pcWriteCond, ALUsrcA, regDst, regWrite, MemtoReg, Memread, Memwrite, instr_done, halted;
  logic [1:0] pcSrc, ALUsrcB, err_code;
  logic [2:0] ALUop;
  int n_err = 0, n_checks = 0, g_cyc = 0, g_done = 0;
  logic [3:0] g_op = 4'h0;

  multicycle_control #(.TIMEOUT(TO), .TW(8)) dut (
    .clock(clock), .reset(reset), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .IRwrite(IRwrite), .IorD(IorD), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .regDst(regDst), .regWrite(regWrite),
    .MemtoReg(MemtoReg), .Memread(Memread), .Memwrite(Memwrite), .instr_done(instr_done),
    .halted(halted), .err_code(err_code)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] alu_want(input logic [3:0] op);
    case (op)
      4'h1: return 3'b001;
      4'h2: return 3'b010;
      4'h6: return 3'b011;
      4'h7: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [20:0] exp_out(input int ph, input bit rdy, input logic [1:0] err);
    logic irw = 0, iord = 0, pcw = 0, pcc = 0, asa = 0, rd = 0, rw = 0, m2r = 0, mr = 0, mw = 0, dn = 0, h = 0;
    logic [1:0] pcs = 0, asb = 0, e = 0;
    logic [2:0] aop = 0;
    case (ph)
      P_FETCH:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; aop = 3'b010; end
      P_DECODE: begin asb = 2'b10; aop = 3'b010; end
      P_EXEC:   begin asa = 1; aop = alu_want(g_op); end
      P_WBR:    begin rd = 1; rw = 1; dn = 1; end
      P_ADDR:   begin asa = 1; asb = 2'b10; aop = 3'b010; end
      P_MRD:    begin mr = 1; iord = 1; end
      P_WLW:    begin rw = 1; m2r = 1; dn = 1; end
      P_MWR:    begin mw = 1; iord = 1; dn = rdy; end
      P_BR:     begin asa = 1; aop = 3'b011; pcc = 1; pcs = 2'b01; dn = 1; end
      P_JMP:    begin pcw = 1; pcs = 2'b10; dn = 1; end
      P_HALT:   begin h = 1; e = err; end
      default: ;
    endcase
    return {irw, iord, pcw, pcc, pcs, asa, asb, aop, rd, rw, m2r, mr, mw, dn, h, e};
  endfunction

  task automatic step(input int ph, input bit rdy, input logic [3:0] op, input logic [1:0] err, input string nm);
    logic [20:0] got, want;
    mem_ready = rdy;
    opCode = op;
    zero = 1'($urandom);
    @(negedge clock);
    want = exp_out(ph, rdy, err);
    got = {IRwrite, IorD, pcWrite, pcWriteCond, pcSrc, ALUsrcA, ALUsrcB, ALUop,
           regDst, regWrite, MemtoReg, Memread, Memwrite, instr_done, halted, err_code};
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s phase=%0d cycle=%0d got=%h want=%h", nm, ph, g_cyc + 1, got, want);
    end
    g_cyc++;
    if (instr_done === 1'b1 && g_done == 0) g_done = g_cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock);
    #1;
    step(P_IDLE, 1, 4'($urandom), 2'b00, "in_reset");
    reset = 1'b0;
    step(P_IDLE, 1, 4'($urandom), 2'b00, "idle");
  endtask

  // fw/mw: cycles mem_ready stays low in FETCH / in the data access
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input string nm);
    int lat, mph;
    g_op = op;
    g_cyc = 0;
    g_done = 0;
    for (int i = 0; i < fw && i < TO; i++) step(P_FETCH, 0, 4'($urandom), 2'b00, nm);
    if (fw >= TO) begin
      step(P_HALT, 1'($urandom), 4'($urandom), 2'b10, nm);
      return;
    end
    step(P_FETCH, 1, 4'($urandom), 2'b00, nm);
    step(P_DECODE, 1'($urandom), op, 2'b00, nm);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7: begin
        step(P_EXEC, 1'($urandom), 4'($urandom), 2'b00, nm);
        step(P_WBR, 1'($urandom), 4'($urandom), 2'b00, nm);
        lat = 4 + fw;
      end
      4'h8, 4'hA: begin
        mph = op == 4'h8 ? P_MRD : P_MWR;
        step(P_ADDR, 1'($urandom), op, 2'b00, nm);
        for (int i = 0; i < mw && i < TO; i++) step(mph, 0, 4'($urandom), 2'b00, nm);
        if (mw >= TO) begin
          step(P_HALT, 1'($urandom), 4'($urandom), 2'b10, nm);
          step(P_HALT, 1'($urandom), 4'($urandom), 2'b10, nm);
          return;
        end
        step(mph, 1, 4'($urandom), 2'b00, nm);
        if (op == 4'h8) step(P_WLW, 1'($urandom), 4'($urandom), 2'b00, nm);
        lat = (op == 4'h8 ? 5 : 4) + fw + mw;
      end
      4'hE: begin step(P_BR, 1'($urandom), 4'($urandom), 2'b00, nm); lat = 3 + fw; end
      4'hF: begin step(P_JMP, 1'($urandom), 4'($urandom), 2'b00, nm); lat = 3 + fw; end
      default: begin
        for (int i = 0; i < 20; i++) step(P_HALT, 1'($urandom), 4'($urandom), 2'b01, nm);
        return;
      end
    endcase
    n_checks++;
    if (g_done != lat) begin
      n_err++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, g_done, lat);
    end
  endtask

  task automatic test_reset();
    do_reset();
    run_instr(4'h2, 0, 0, "first_add");
  endtask

  task automatic test_rtype();
    logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7};
    foreach (ops[i]) run_instr(ops[i], $urandom_range(0, 2), 0, "rtype");
  endtask

  task automatic test_load_store();
    run_instr(4'h8, 0, 3, "lw_wait");
    run_instr(4'h8, 0, 0, "lw");
    run_instr(4'hA, 1, 0, "sw");
    run_instr(4'hA, 0, 2, "sw_wait");
  endtask

  task automatic test_branch_jump();
    run_instr(4'hE, 0, 0, "bne_a");
    run_instr(4'hE, 0, 0, "bne_b");
    run_instr(4'hF, 0, 0, "jmp");
  endtask

  task automatic test_illegal();
    logic [3:0] bad [7] = '{4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD};
    run_instr(4'h3, 0, 0, "illegal3");
    do_reset();
    run_instr(bad[$urandom_range(1, 6)], 0, 0, "illegal_rand");
    do_reset();
  endtask

  task automatic test_timeout();
    run_instr(4'hA, 0, 4, "sw_timeout");
    do_reset();
    run_instr(4'hA, 0, 3, "sw_edge");
    run_instr(4'h8, 0, 6, "lw_timeout");
    do_reset();
    run_instr(4'h8, 0, 3, "lw_edge");
    run_instr(4'h2, 4, 0, "fetch_timeout");
    do_reset();
    run_instr(4'h2, 3, 0, "fetch_edge");
  endtask

  task automatic test_back_to_back();
    logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE, 4'hF};
    for (int i = 0; i < 40; i++)
      run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3), "b2b");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the 4-bit-opcode RISC datapath. It replaces the single-cycle decode with a Moore FSM that spreads each instruction over fetch, decode, execute, memory and writeback cycles, and shares one ALU and one memory port across those steps. It adds a memory-ready handshake, a memory timeout and an illegal-opcode halt. It sits between the instruction register and the datapath muxes, register-file write enable and memory strobes.

Parameters:
TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory state before halting (1..255)
TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opCode  input  4  opcode from instruction register (valid from DECODE onward)
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
IRwrite  output  1  load instruction register
IorD  output  1  memory address: 0=PC, 1=ALUOut
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if zero==0 (BNE)
pcSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
ALUsrcA  output  1  0=PC, 1=regA
ALUsrcB  output  2  00=regB, 01=constant 1, 10=sign-extended immediate
ALUop  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT
regDst  output  1  destination register: 1=rd, 0=rt
regWrite  output  1  register file write enable
MemtoReg  output  1  writeback source: 1=MDR, 0=ALUOut
Memread  output  1  memory read strobe
Memwrite  output  1  memory write strobe
instr_done  output  1  one-cycle pulse in an instruction's final cycle
halted  output  1  sticky; FSM is in HALT
err_code  output  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset is synchronous and active-high. Clock and reset are the single clock domain.
- On reset, go to IDLE. In IDLE all outputs are 0, err_code=00 and the timeout counter is 0. Reset overrides any state, including HALT and mid-access.
- Outputs are a pure decode of the registered state (Moore). Any output not listed for a state is 0.
- IDLE -> FETCH unconditionally.
- FETCH: Memread=1, IorD=0, IRwrite=1, ALUsrcA=0, ALUsrcB=01, ALUop=010, pcSrc=00.
  - IRwrite and pcWrite are qualified: they assert only in the cycle where mem_ready=1, and the FSM moves to DECODE in that cycle.
  - Otherwise the FSM stays in FETCH.
- DECODE: ALUsrcA=0, ALUsrcB=10, ALUop=010 (branch target into ALUOut). Next state by opCode:
  - 0, 1, 2, 6, 7 -> EXEC_R
  - 8, A -> ADDR
  - E -> BRANCH
  - F -> JUMP
  - any other opcode -> HALT with err_code=01
- EXEC_R: ALUsrcA=1, ALUsrcB=00. ALUop = 000/001/010/011/111 for opcodes 0/1/2/6/7. -> WB_R.
- WB_R: regDst=1, regWrite=1, MemtoReg=0, instr_done=1. -> FETCH.
- ADDR: ALUsrcA=1, ALUsrcB=10, ALUop=010. -> MEM_RD for opcode 8, MEM_WR for opcode A.
- MEM_RD: Memread=1, IorD=1. On mem_ready -> WB_LW.
- WB_LW: regDst=0, regWrite=1, MemtoReg=1, instr_done=1. -> FETCH.
- MEM_WR: Memwrite=1, IorD=1. On mem_ready: instr_done=1 and -> FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=011, pcWriteCond=1, pcSrc=01, instr_done=1. -> FETCH.
  - The PC is updated only when zero=0. The datapath performs that gating.
- JUMP: pcWrite=1, pcSrc=10, instr_done=1. -> FETCH.
- Memory timeout:
  - The counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle the FSM stays there with mem_ready=0.
  - If the count reaches TIMEOUT with mem_ready still 0, go to HALT with err_code=10 and drop the strobes on the next cycle.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT counts as success.
- HALT: all strobes 0, halted=1. err_code holds its value until reset.
- Latency with mem_ready held high:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BNE: 3 cycles
  - JMP: 3 cycles
- opCode is sampled only in DECODE and ADDR. Changes in other states are ignored.

Decomposition:
- Shared package holds:
  - opcode constants (OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_LW=8, OP_SW=A, OP_BNE=E, OP_JMP=F)
  - ALUop encodings
  - pcSrc and ALUsrcB encodings
  - err_code values
  - state enumeration (4-bit)
- One sub-module, mc_timeout_counter: clear, enable, terminal-count flag. It is parameterised by TIMEOUT and TW.

Test Plan:
- Reset held for 2 cycles, then released, mem_ready=1 -> all outputs 0 during reset; IDLE, then FETCH with Memread=1, ALUsrcB=01, pcWrite=1.
- opCode=2 (ADD), mem_ready=1 -> regWrite=1 and instr_done=1 in cycle 4; ALUop=010 in EXEC_R. opCode=7 -> ALUop=111.
- opCode=8 (LW), mem_ready low for 3 cycles in MEM_RD -> Memread=1 and IorD=1 held 4 cycles; WB_LW with MemtoReg=1 and regWrite=1; total 8 cycles.
- opCode=E with zero=0, then zero=1 -> pcWriteCond=1, pcSrc=01, ALUop=011 in cycle 3 both times; instr_done pulses once each time.
- opCode=3 -> HALT after DECODE, halted=1, err_code=01, stays there for 20 cycles; reset returns to IDLE with err_code=00.
- TIMEOUT=4, opCode=A, mem_ready=0 -> Memwrite=1 for 4 cycles, then HALT with err_code=10 and Memwrite=0. Repeat with mem_ready=1 on the 4th cycle -> completes normally with instr_done=1.
